afifo_pkt_writer: RTL and testbench
===================================

# afifo_pkt_writer

Write-domain packet producer for the dual-clock FIFO. Accepts a valid/ready beat stream on wclk, stores one packet in a local buffer, then pushes a length header word followed by the payload into the FIFO write port (wreq/wdata/wfull). The read-domain consumer parses the header to learn packet length. Oversized packets are truncated and flagged in the header.

## Interface
- DSIZE, 8: FIFO word width and beat width; must be >= LSIZE+2.
- LSIZE, 4: log2 of local buffer depth; MAXLEN = 2^LSIZE beats.
- SAFE_GAP, 1: 1 = never write on the cycle after a write (covers the FIFO's one-cycle-late registered wfull); 0 = back-to-back writes.
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, asynchronous, active-low; clock wclk.
- s_valid  in  1  source beat valid.
- s_ready  out  1  block accepts beat when s_valid & s_ready at wclk rise.
- s_data  in  DSIZE  beat payload.
- s_last  in  1  final beat of packet.
- wreq  out  1  FIFO write request (combinational from state, wfull, gap flag).
- wdata  out  DSIZE  FIFO write data, valid while wreq=1.
- wfull  in  1  FIFO full, wclk domain.
- pkt_done  out  1  one-cycle pulse after final payload word written.
- pkt_count  out  16  packets fully written since reset, wraps at 65535->0.

## Operation
- States: COLLECT, DRAIN, HEADER, PAYLOAD. Reset state COLLECT.
- COLLECT: s_ready=1. Each accepted beat stored at buf[cnt], cnt++. Accepted beat with s_last -> len=cnt+1, trunc=0, go HEADER. Accepted beat filling buffer (cnt=MAXLEN-1) without s_last -> len=MAXLEN, trunc=1, go DRAIN.
- DRAIN: s_ready=1; beats discarded; accepted beat with s_last -> HEADER.
- HEADER: wdata = {trunc, zeros, len[LSIZE:0]} (trunc at bit DSIZE-1, len in bits LSIZE..0). On write -> PAYLOAD, rd=0.
- PAYLOAD: wdata=buf[rd]; on write rd++; write of rd=len-1 -> COLLECT, cnt=0, pkt_done=1 next cycle, pkt_count++.
- s_ready=0 in HEADER and PAYLOAD.
- wreq = (HEADER|PAYLOAD) & !wfull & !(SAFE_GAP & wr_q); wr_q = registered wreq. A write occurs at every wclk rise with wreq=1; no word is ever re-sent or skipped.
- len is 1..MAXLEN; zero-length packets impossible.
- Reset (any state, any time): state COLLECT, cnt=rd=0, wr_q=0, pkt_done=0, pkt_count=0, trunc=0; wreq drops to 0 immediately (async). Partially written packet is abandoned; buffer contents need no clearing.

## Timing
- Reset values: s_ready=1, wreq=0, wdata=0 (undefined-free: header mux default), pkt_done=0, pkt_count=0.
- Last beat accepted at edge k -> HEADER in cycle after k; header written at edge k+1 if wfull=0.
- SAFE_GAP=1, wfull=0: writes at k+1, k+3, ..., header + N payload words complete at edge k+1+2N; pkt_done high in cycle after that edge; s_ready=1 same cycle.
- SAFE_GAP=0, wfull=0: writes at k+1..k+1+N consecutive.
- wfull=1 stalls wreq combinationally in the same cycle; resume on first cycle with wfull=0 (and gap satisfied).
- pkt_count updates on the same edge pkt_done rises.

## Test plan
- SAFE_GAP=1, wfull=0, packet 0xA1,0xA2,0xA3(last) -> FIFO sees 0x03,0xA1,0xA2,0xA3 on alternating cycles; one pkt_done pulse; pkt_count=1.
- Same packet, wfull forced 1 for 5 cycles after header write -> wreq=0 throughout, then 0xA1..0xA3 written once each, none lost or duplicated.
- LSIZE=4, 20-beat packet 0x00..0x13 -> header 0x90, payload 0x00..0x0F, beats 0x10..0x13 dropped with s_ready=1 during DRAIN.
- Single beat 0x5C with s_last -> header 0x01 then 0x5C; back-to-back second packet accepted immediately after pkt_done.
- wrst_n asserted during PAYLOAD after 2 of 4 words -> wreq=0 at once, s_ready=1, pkt_count=0; next packet starts fresh with correct header.
- SAFE_GAP=0, 16-beat packet -> 17 writes on 17 consecutive edges.

Source files
------------

// File: rtl/afifo_pkt_writer.sv
// Write-domain packet producer: buffers one packet from a valid/ready beat stream,
// then pushes a length header followed by the payload into the async FIFO write port.
module afifo_pkt_writer #(
  parameter int DSIZE    = 8,
  parameter int LSIZE    = 4,
  parameter int SAFE_GAP = 1
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_last,
  output logic             wreq,
  output logic [DSIZE-1:0] wdata,
  input  logic             wfull,
  output logic             pkt_done,
  output logic [15:0]      pkt_count
);

  // state   | meaning
  // COLLECT | accept beats into the local buffer
  // DRAIN   | buffer full, discard beats until s_last
  // HEADER  | write {trunc, len} header word
  // PAYLOAD | write buffered beats buf_mem[0..len-1]
  typedef enum logic [1:0] {COLLECT, DRAIN, HEADER, PAYLOAD} state_t;

  localparam int   MAXLEN = 1 << LSIZE;
  localparam logic GAP_EN = (SAFE_GAP != 0);

  state_t           state, state_nxt;
  logic [LSIZE-1:0] cnt, rd;
  logic [LSIZE:0]   len;
  logic             trunc, wr_q;
  logic             accept, last_word;
  logic [DSIZE-1:0] buf_mem [MAXLEN];

  assign accept    = s_valid & s_ready;
  assign last_word = (state == PAYLOAD) && ({1'b0, rd} == (len - 1'b1));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= COLLECT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept) begin
        if (s_last)    state_nxt = HEADER;
        else if (&cnt) state_nxt = DRAIN;
      end
      DRAIN:   if (accept && s_last) state_nxt = HEADER;
      HEADER:  if (wreq) state_nxt = PAYLOAD;
      PAYLOAD: if (wreq && last_word) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // wr_q gap term absorbs the FIFO's one-cycle-late registered wfull
  always_comb begin
    s_ready = (state == COLLECT) || (state == DRAIN);
    wreq    = ((state == HEADER) || (state == PAYLOAD)) && !wfull && !(GAP_EN && wr_q);
    wdata   = '0;
    if (state == HEADER) begin
      wdata[LSIZE:0]   = len;
      wdata[DSIZE-1]   = trunc;
    end else if (state == PAYLOAD) begin
      wdata = buf_mem[rd];
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      cnt       <= '0;
      rd        <= '0;
      len       <= '0;
      trunc     <= 1'b0;
      wr_q      <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_count <= '0;
    end else begin
      wr_q     <= wreq;
      pkt_done <= 1'b0;
      case (state)
        COLLECT: if (accept) begin
          cnt <= cnt + 1'b1;
          if (s_last) begin
            len   <= {1'b0, cnt} + 1'b1;
            trunc <= 1'b0;
          end else if (&cnt) begin
            len   <= (LSIZE+1)'(MAXLEN);
            trunc <= 1'b1;
          end
        end
        HEADER: if (wreq) rd <= '0;
        PAYLOAD: if (wreq) begin
          rd <= rd + 1'b1;
          if (last_word) begin
            cnt       <= '0;
            pkt_done  <= 1'b1;
            pkt_count <= pkt_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer holds no reset: stale contents are never read before being rewritten
  always_ff @(posedge wclk) begin
    if (state == COLLECT && accept) buf_mem[cnt] <= s_data;
  end

endmodule

// File: tb/tb_afifo_pkt_writer.sv
// Bench for afifo_pkt_writer: queue-based packet model checked every cycle on the
// SAFE_GAP=1 instance, plus directed literal checks and a SAFE_GAP=0 instance.
module tb_afifo_pkt_writer;
  localparam int MAXLEN = 16;

  logic        wclk = 1'b0, wrst_n = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, wfull = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, wreq, pkt_done;
  logic [7:0]  wdata;
  logic [15:0] pkt_count;

  logic        v0 = 1'b0, l0 = 1'b0;
  logic [7:0]  d0 = '0;
  logic        r0, wreq0, done0;
  logic [7:0]  wdata0;
  logic [15:0] cnt0;

  always #5 wclk = ~wclk;

  afifo_pkt_writer #(.DSIZE(8), .LSIZE(4), .SAFE_GAP(1)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .wreq(wreq), .wdata(wdata), .wfull(wfull),
    .pkt_done(pkt_done), .pkt_count(pkt_count));

  afifo_pkt_writer #(.DSIZE(8), .LSIZE(4), .SAFE_GAP(0)) dut0 (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(v0), .s_ready(r0),
    .s_data(d0), .s_last(l0), .wreq(wreq0), .wdata(wdata0), .wfull(1'b0),
    .pkt_done(done0), .pkt_count(cnt0));

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [7:0] exp_d[$];
  bit         exp_l[$];
  logic [7:0] wlog_d[$];
  int         wlog_c[$];
  logic [7:0] w0_d[$];
  int         w0_c[$];
  int         ndone0 = 0;
  int         model_count = 0;
  bit         done_next = 0, prev_wreq = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  always @(posedge wclk) cyc++;

  // Compare process: every mid-cycle, outputs must match the packet queue model
  always @(negedge wclk) begin
    if (!wrst_n) begin
      exp_d.delete();
      exp_l.delete();
      done_next   = 0;
      model_count = 0;
      prev_wreq   = 0;
    end else begin
      if (done_next) model_count = (model_count + 1) & 16'hFFFF;
      chk("pkt_done", pkt_done, done_next);
      chk("pkt_count", pkt_count, model_count);
      chk("s_ready", s_ready, exp_d.size() == 0);
      if (wfull) chk("wreq_during_full", wreq, 0);
      done_next = 0;
      if (wreq) begin
        chk("write_gap", prev_wreq, 0);
        wlog_d.push_back(wdata);
        wlog_c.push_back(cyc);
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h expected no write", wdata);
        end else begin
          chk("wdata", wdata, exp_d[0]);
          done_next = exp_l[0];
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
        end
      end
      prev_wreq = wreq;
    end
  end

  always @(negedge wclk) begin
    if (wrst_n && wreq0) begin
      w0_d.push_back(wdata0);
      w0_c.push_back(cyc);
    end
    if (wrst_n && done0) ndone0++;
  end

  task automatic send(input int n, input logic [7:0] base, input logic [7:0] step);
    int budget = 0;
    int plen;
    while ((exp_d.size() != 0 || !s_ready) && budget < 300) begin
      @(posedge wclk); #1;
      budget++;
    end
    if (budget >= 300) timeout("send_idle");
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(base + i * step);
      s_last  = (i == n - 1);
      @(posedge wclk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    plen = (n > MAXLEN) ? MAXLEN : n;
    exp_d.push_back((n > MAXLEN) ? (8'h80 | 8'(MAXLEN)) : 8'(n));
    exp_l.push_back(1'b0);
    for (int i = 0; i < plen; i++) begin
      exp_d.push_back(8'(base + i * step));
      exp_l.push_back(i == plen - 1);
    end
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (exp_d.size() != 0 && budget < 300) begin
      @(posedge wclk); #1;
      budget++;
    end
    if (budget >= 300) timeout("drain");
    repeat (2) @(posedge wclk);
    #1;
  endtask

  initial begin
    int n0, budget;
    repeat (2) @(posedge wclk);
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_wreq", wreq, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_wreq0", wreq0, 0);
    wrst_n = 1'b1;
    @(posedge wclk); #1;

    // basic 3-beat packet, alternating-cycle writes
    n0 = wlog_d.size();
    send(3, 8'hA1, 8'h01);
    wait_idle();
    chk("t1_nwrites", wlog_d.size() - n0, 4);
    chk("t1_hdr", wlog_d[n0], 8'h03);
    chk("t1_w1", wlog_d[n0+1], 8'hA1);
    chk("t1_w3", wlog_d[n0+3], 8'hA3);
    for (int i = 0; i < 3; i++) chk("t1_spacing", wlog_c[n0+i+1] - wlog_c[n0+i], 2);
    chk("t1_count", pkt_count, 1);

    // wfull stall for 5 cycles after header
    n0 = wlog_d.size();
    send(3, 8'hA1, 8'h01);
    @(posedge wclk); #1;
    wfull = 1'b1;
    repeat (5) @(posedge wclk);
    #1;
    chk("t2_stalled_writes", wlog_d.size() - n0, 1);
    wfull = 1'b0;
    wait_idle();
    chk("t2_nwrites", wlog_d.size() - n0, 4);
    chk("t2_w2", wlog_d[n0+2], 8'hA2);
    chk("t2_count", pkt_count, 2);

    // oversize packet truncated to 16 beats
    n0 = wlog_d.size();
    send(20, 8'h00, 8'h01);
    wait_idle();
    chk("t3_nwrites", wlog_d.size() - n0, 17);
    chk("t3_hdr", wlog_d[n0], 8'h90);
    chk("t3_last", wlog_d[n0+16], 8'h0F);
    chk("t3_count", pkt_count, 3);

    // single-beat packet then back-to-back second packet
    n0 = wlog_d.size();
    send(1, 8'h5C, 8'h00);
    send(2, 8'h60, 8'h01);
    wait_idle();
    chk("t4_nwrites", wlog_d.size() - n0, 5);
    chk("t4_hdr1", wlog_d[n0], 8'h01);
    chk("t4_pay1", wlog_d[n0+1], 8'h5C);
    chk("t4_hdr2", wlog_d[n0+2], 8'h02);
    chk("t4_count", pkt_count, 5);

    // reset mid-PAYLOAD after 2 of 4 words
    n0 = wlog_d.size();
    send(3, 8'h11, 8'h11);
    budget = 0;
    while (wlog_d.size() < n0 + 2 && budget < 50) begin
      @(posedge wclk); #1;
      budget++;
    end
    if (budget >= 50) timeout("t5_two_words");
    @(posedge wclk); #1;
    chk("t5_wreq_pre", wreq, 1);
    wrst_n = 1'b0;
    #1;
    chk("t5_wreq_rst", wreq, 0);
    chk("t5_s_ready_rst", s_ready, 1);
    chk("t5_count_rst", pkt_count, 0);
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    @(posedge wclk); #1;
    send(2, 8'h44, 8'h11);
    wait_idle();
    chk("t5_nwrites", wlog_d.size() - n0, 5);
    chk("t5_hdr", wlog_d[n0+2], 8'h02);
    chk("t5_pay", wlog_d[n0+4], 8'h55);
    chk("t5_count", pkt_count, 1);

    // SAFE_GAP=0: 16-beat packet, 17 consecutive writes
    for (int i = 0; i < 16; i++) begin
      v0 = 1'b1;
      d0 = 8'(i);
      l0 = (i == 15);
      @(posedge wclk); #1;
    end
    v0 = 1'b0;
    l0 = 1'b0;
    repeat (25) @(posedge wclk);
    #1;
    chk("t6_nwrites", w0_d.size(), 17);
    if (w0_d.size() == 17) begin
      chk("t6_hdr", w0_d[0], 8'h10);
      for (int i = 1; i < 17; i++) begin
        chk("t6_pay", w0_d[i], 8'(i - 1));
        chk("t6_consecutive", w0_c[i] - w0_c[0], i);
      end
    end
    chk("t6_done_pulses", ndone0, 1);
    chk("t6_count", cnt0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
